// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one line-refill memory port between the ICache
// (line fills) and the DCache (line reads / write-backs).
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_req_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic              ic_ready_o,
  output logic [LINE_W-1:0] ic_data_o,
  input  logic              dc_req_i,
  input  logic              dc_we_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [LINE_W-1:0] dc_wdata_i,
  output logic              dc_ready_o,
  output logic [LINE_W-1:0] dc_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic              mem_ready_i,
  input  logic [LINE_W-1:0] mem_rdata_i
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY_IC = 2'd1;
  localparam logic [1:0] BUSY_DC = 2'd2;

  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-4){1'b1}}, 4'b0000};

  function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] a);
    return a & LINE_MASK;
  endfunction

  logic [1:0]        state_r;
  logic              pend_ic_r;
  logic              pend_dc_r;
  logic              ic_stale_r;
  logic              last_dc_r;
  logic [ADDR_W-1:0] ic_addr_r;
  logic              dc_we_r;
  logic [ADDR_W-1:0] dc_addr_r;
  logic [LINE_W-1:0] dc_wdata_r;

  logic              cand_ic_s;
  logic              cand_dc_s;
  logic              grant_ic_s;
  logic              grant_dc_s;
  logic              done_s;
  logic [ADDR_W-1:0] ic_addr_s;
  logic              dc_we_s;
  logic [ADDR_W-1:0] dc_addr_s;
  logic [LINE_W-1:0] dc_wdata_s;

  // Arbitration: same-cycle pulses count as candidates and override latched fields.
  always_comb begin
    cand_ic_s  = pend_ic_r | ic_req_i;
    cand_dc_s  = pend_dc_r | dc_req_i;
    ic_addr_s  = ic_req_i ? ic_addr_i : ic_addr_r;
    dc_we_s    = dc_req_i ? dc_we_i : dc_we_r;
    dc_addr_s  = dc_req_i ? dc_addr_i : dc_addr_r;
    dc_wdata_s = dc_req_i ? dc_wdata_i : dc_wdata_r;
    done_s     = mem_req_o & mem_ready_i;
    grant_ic_s = 1'b0;
    grant_dc_s = 1'b0;
    if (state_r == IDLE) begin
      if (cand_ic_s && cand_dc_s) begin
        grant_ic_s = last_dc_r;
        grant_dc_s = ~last_dc_r;
      end else begin
        grant_ic_s = cand_ic_s;
        grant_dc_s = cand_dc_s;
      end
    end else begin
      grant_ic_s = 1'b0;
      grant_dc_s = 1'b0;
    end
  end

  // Request capture; a grant in the same cycle consumes the pending request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_ic_r  <= 1'b0;
      pend_dc_r  <= 1'b0;
      ic_addr_r  <= '0;
      dc_we_r    <= 1'b0;
      dc_addr_r  <= '0;
      dc_wdata_r <= '0;
    end else begin
      if (ic_req_i) begin
        ic_addr_r <= ic_addr_i;
      end
      if (dc_req_i) begin
        dc_we_r    <= dc_we_i;
        dc_addr_r  <= dc_addr_i;
        dc_wdata_r <= dc_wdata_i;
      end
      if (grant_ic_s) begin
        pend_ic_r <= 1'b0;
      end else if (ic_req_i) begin
        pend_ic_r <= 1'b1;
      end
      if (grant_dc_s) begin
        pend_dc_r <= 1'b0;
      end else if (dc_req_i) begin
        pend_dc_r <= 1'b1;
      end
    end
  end

  // Transaction FSM and registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      last_dc_r   <= 1'b1;
      ic_stale_r  <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      ic_ready_o  <= 1'b0;
      ic_data_o   <= '0;
      dc_ready_o  <= 1'b0;
      dc_rdata_o  <= '0;
    end else begin
      ic_ready_o <= 1'b0;
      dc_ready_o <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_ic_s) begin
            state_r     <= BUSY_IC;
            last_dc_r   <= 1'b0;
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= line_addr(ic_addr_s);
            mem_wdata_o <= '0;
          end else if (grant_dc_s) begin
            state_r     <= BUSY_DC;
            last_dc_r   <= 1'b1;
            mem_req_o   <= 1'b1;
            mem_we_o    <= dc_we_s;
            mem_addr_o  <= line_addr(dc_addr_s);
            mem_wdata_o <= dc_wdata_s;
          end
        end
        BUSY_IC: begin
          // A re-pulse on the completion edge also supersedes the returning line.
          if (done_s) begin
            state_r    <= IDLE;
            mem_req_o  <= 1'b0;
            ic_stale_r <= 1'b0;
            if (!ic_stale_r && !ic_req_i) begin
              ic_ready_o <= 1'b1;
              ic_data_o  <= mem_rdata_i;
            end
          end else if (ic_req_i) begin
            ic_stale_r <= 1'b1;
          end
        end
        BUSY_DC: begin
          if (done_s) begin
            state_r    <= IDLE;
            mem_req_o  <= 1'b0;
            dc_ready_o <= 1'b1;
            if (!mem_we_o) begin
              dc_rdata_o <= mem_rdata_i;
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          mem_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed pulses push expected memory
// transactions and responses; a monitor pops and compares them.
module tb_mem_bus_arbiter;
  localparam int AW = 32;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ic_req_i = 1'b0;
  logic [AW-1:0] ic_addr_i = '0;
  logic          ic_ready_o;
  logic [LW-1:0] ic_data_o;
  logic          dc_req_i = 1'b0;
  logic          dc_we_i = 1'b0;
  logic [AW-1:0] dc_addr_i = '0;
  logic [LW-1:0] dc_wdata_i = '0;
  logic          dc_ready_o;
  logic [LW-1:0] dc_rdata_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [LW-1:0] mem_wdata_o;
  logic          mem_ready_i = 1'b0;
  logic [LW-1:0] mem_rdata_i = '0;

  mem_bus_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i),
    .ic_ready_o(ic_ready_o), .ic_data_o(ic_data_o),
    .dc_req_i(dc_req_i), .dc_we_i(dc_we_i), .dc_addr_i(dc_addr_i),
    .dc_wdata_i(dc_wdata_i), .dc_ready_o(dc_ready_o), .dc_rdata_o(dc_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  // expected memory transactions (written by stimulus, read by monitor)
  logic          xm_we   [0:31];
  logic [AW-1:0] xm_addr [0:31];
  logic [LW-1:0] xm_wd   [0:31];
  int            xm_cyc  [0:31];
  int            mem_wr = 0;
  int            mem_rd = 0;
  // expected cache responses
  logic          xr_dc   [0:31];
  logic [LW-1:0] xr_data [0:31];
  int            rsp_wr = 0;
  int            rsp_rd = 0;

  int   errors = 0;
  int   checks = 0;
  int   cycle = 0;
  int   lat = 3;
  int   idle_req = 0;
  int   idle_served = 0;
  logic final_req = 1'b0;
  logic final_done = 1'b0;

  localparam logic [LW-1:0] A5_LINE = {16{8'hA5}};

  function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
    return {4{a ^ 32'hCAFE_F00D}};
  endfunction

  task automatic exp_mem(input logic we, input logic [AW-1:0] a, input logic [LW-1:0] wd, input int cyc);
    xm_we[mem_wr] = we; xm_addr[mem_wr] = a; xm_wd[mem_wr] = wd; xm_cyc[mem_wr] = cyc;
    mem_wr++;
  endtask

  task automatic exp_rsp(input logic is_dc, input logic [LW-1:0] d);
    xr_dc[rsp_wr] = is_dc; xr_data[rsp_wr] = d;
    rsp_wr++;
  endtask

  task automatic pulse(input logic ic, input logic [AW-1:0] ia, input logic dc,
                       input logic we, input logic [AW-1:0] da, input logic [LW-1:0] wd);
    ic_req_i = ic; ic_addr_i = ia;
    dc_req_i = dc; dc_we_i = we; dc_addr_i = da; dc_wdata_i = wd;
    @(negedge clk);
    ic_req_i = 1'b0; dc_req_i = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (mem_rd == mem_wr && rsp_rd == rsp_wr && !mem_req_o) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20; i++) begin
      if (mem_req_o) break;
      @(negedge clk);
    end
  endtask

  // Memory responder: ready after 'lat' busy cycles, plus injected idle pulses.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        mem_ready_i = 1'b0; cnt = 0;
      end else if (mem_ready_i) begin
        mem_ready_i = 1'b0; cnt = 0;
      end else if (idle_served != idle_req) begin
        mem_ready_i = 1'b1; mem_rdata_i = {4{32'hBAD0_BAD0}};
        idle_served++;
      end else if (mem_req_o) begin
        cnt++;
        if (cnt >= lat) begin
          mem_ready_i = 1'b1; mem_rdata_i = line_of(mem_addr_o);
        end
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    logic          prev_req;
    logic          prev_rdy;
    logic          h_we;
    logic [AW-1:0] h_addr;
    logic [LW-1:0] h_wd;
    logic [LW-1:0] got;
    prev_req = 1'b0; prev_rdy = 1'b0; h_we = 1'b0; h_addr = '0; h_wd = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        #1;
        checks++;
        if ({mem_req_o, mem_we_o, ic_ready_o, dc_ready_o} !== 4'b0000 || mem_addr_o !== '0 ||
            mem_wdata_o !== '0 || ic_data_o !== '0 || dc_rdata_o !== '0) begin
          errors++;
          $display("FAIL reset_outputs: got req=%b we=%b icr=%b dcr=%b addr=%h, required all zero",
                   mem_req_o, mem_we_o, ic_ready_o, dc_ready_o, mem_addr_o);
        end
        prev_req = 1'b0; prev_rdy = 1'b0;
      end else begin
        #2;
        cycle++;
        if (ic_ready_o && dc_ready_o) begin
          checks++; errors++;
          $display("FAIL ready_exclusive: both ready outputs high at cycle %0d, required at most one", cycle);
        end
        if (ic_ready_o || dc_ready_o) begin
          checks++;
          got = dc_ready_o ? dc_rdata_o : ic_data_o;
          if (rsp_rd == rsp_wr) begin
            errors++;
            $display("FAIL unexpected_ready: got icr=%b dcr=%b at cycle %0d, required no response", ic_ready_o, dc_ready_o, cycle);
          end else begin
            if (xr_dc[rsp_rd] !== dc_ready_o || xr_data[rsp_rd] !== got) begin
              errors++;
              $display("FAIL response: got dc=%b data=%h, required dc=%b data=%h",
                       dc_ready_o, got, xr_dc[rsp_rd], xr_data[rsp_rd]);
            end
            rsp_rd++;
          end
        end
        if (prev_req) begin
          checks++;
          if (mem_req_o !== !prev_rdy) begin
            errors++;
            $display("FAIL req_level: got mem_req_o=%b after ready=%b, required %b", mem_req_o, prev_rdy, !prev_rdy);
          end
        end
        if (mem_req_o && prev_req) begin
          checks++;
          if (mem_we_o !== h_we || mem_addr_o !== h_addr || mem_wdata_o !== h_wd) begin
            errors++;
            $display("FAIL req_hold: got we=%b addr=%h, required we=%b addr=%h", mem_we_o, mem_addr_o, h_we, h_addr);
          end
        end
        if (mem_req_o && !prev_req) begin
          checks++;
          if (mem_rd == mem_wr) begin
            errors++;
            $display("FAIL unexpected_txn: got addr=%h we=%b at cycle %0d, required no transaction", mem_addr_o, mem_we_o, cycle);
          end else begin
            if (mem_we_o !== xm_we[mem_rd] || mem_addr_o !== xm_addr[mem_rd] || mem_wdata_o !== xm_wd[mem_rd]) begin
              errors++;
              $display("FAIL txn: got we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                       mem_we_o, mem_addr_o, mem_wdata_o, xm_we[mem_rd], xm_addr[mem_rd], xm_wd[mem_rd]);
            end
            if (xm_cyc[mem_rd] >= 0 && cycle != xm_cyc[mem_rd]) begin
              errors++;
              $display("FAIL txn_latency: got cycle %0d, required cycle %0d", cycle, xm_cyc[mem_rd]);
            end
            mem_rd++;
          end
          h_we = mem_we_o; h_addr = mem_addr_o; h_wd = mem_wdata_o;
        end
        if (final_req && !final_done) begin
          checks++;
          if (mem_rd != mem_wr || rsp_rd != rsp_wr) begin
            errors++;
            $display("FAIL drained: got txn %0d/%0d rsp %0d/%0d seen, required all seen", mem_rd, mem_wr, rsp_rd, rsp_wr);
          end
          final_done = 1'b1;
        end
        prev_req = mem_req_o; prev_rdy = mem_ready_i;
      end
    end
  end

  // Stimulus
  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // first tie after reset: IC wins, DC follows after an idle cycle
    exp_mem(1'b0, 32'h0000_0400, '0, cycle + 1);
    exp_mem(1'b0, 32'h0000_0800, '0, -1);
    exp_rsp(1'b0, line_of(32'h0000_0400));
    exp_rsp(1'b1, line_of(32'h0000_0800));
    pulse(1'b1, 32'h0000_0400, 1'b1, 1'b0, 32'h0000_0808, '0);
    drain();

    // lone IC fill, low address bits cleared
    exp_mem(1'b0, 32'h0000_1230, '0, cycle + 1);
    exp_rsp(1'b0, line_of(32'h0000_1230));
    pulse(1'b1, 32'h0000_1234, 1'b0, 1'b0, '0, '0);
    drain();

    // tie with IC granted last: DC wins
    exp_mem(1'b0, 32'h0000_0900, '0, cycle + 1);
    exp_mem(1'b0, 32'h0000_0500, '0, -1);
    exp_rsp(1'b1, line_of(32'h0000_0900));
    exp_rsp(1'b0, line_of(32'h0000_0500));
    pulse(1'b1, 32'h0000_0500, 1'b1, 1'b0, 32'h0000_0900, '0);
    drain();

    // DC write-back: rdata keeps the previous read line
    exp_mem(1'b1, 32'h8000_0040, A5_LINE, cycle + 1);
    exp_rsp(1'b1, line_of(32'h0000_0900));
    pulse(1'b0, '0, 1'b1, 1'b1, 32'h8000_0040, A5_LINE);
    drain();

    // IC re-pulse while in flight: first response dropped
    lat = 6;
    exp_mem(1'b0, 32'h0000_0100, '0, cycle + 1);
    exp_mem(1'b0, 32'h0000_0200, '0, -1);
    exp_rsp(1'b0, line_of(32'h0000_0200));
    pulse(1'b1, 32'h0000_0100, 1'b0, 1'b0, '0, '0);
    wait_req();
    repeat (2) @(negedge clk);
    pulse(1'b1, 32'h0000_0200, 1'b0, 1'b0, '0, '0);
    drain();

    // reset during BUSY_DC with an IC request pending
    lat = 8;
    exp_mem(1'b0, 32'h0000_3000, '0, cycle + 1);
    pulse(1'b0, '0, 1'b1, 1'b0, 32'h0000_3000, '0);
    wait_req();
    pulse(1'b1, 32'h0000_0700, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // stray mem_ready_i while idle, then a normal DC read
    lat = 3;
    idle_req++;
    repeat (5) @(negedge clk);
    exp_mem(1'b0, 32'h0000_0040, '0, cycle + 1);
    exp_rsp(1'b1, line_of(32'h0000_0040));
    pulse(1'b0, '0, 1'b1, 1'b0, 32'h0000_004C, '0);
    drain();

    final_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (final_done) break;
      @(negedge clk);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single 128-bit line-refill memory port between the instruction cache (read-only line fills) and the data cache (line reads and line write-backs).
- Captures one-cycle request pulses from each cache and arbitrates round-robin on ties.
- Drives a level-held request to memory and routes the ready pulse and line data back to the owning cache.
- Discards instruction-fetch responses superseded by a jump re-request.

Parameters:
ADDR_W, 32, byte address width; line-aligned, low 4 bits forced to 0 on mem_addr_o
LINE_W, 128, cache line width in bits

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
ic_req_i  input  1  one-cycle ICache refill request pulse
ic_addr_i  input  ADDR_W  ICache refill address, valid with ic_req_i
ic_ready_o  output  1  one-cycle pulse: ic_data_o valid
ic_data_o  output  LINE_W  returned instruction line
dc_req_i  input  1  one-cycle DCache request pulse
dc_we_i  input  1  1 = write-back, 0 = line read; valid with dc_req_i
dc_addr_i  input  ADDR_W  DCache line address
dc_wdata_i  input  LINE_W  write-back line; valid with dc_req_i when dc_we_i=1
dc_ready_o  output  1  one-cycle pulse: read data valid or write done
dc_rdata_o  output  LINE_W  returned data line
mem_req_o  output  1  level request to memory, held until mem_ready_i
mem_we_o  output  1  write enable of current transaction
mem_addr_o  output  ADDR_W  line address of current transaction
mem_wdata_o  output  LINE_W  write data of current transaction
mem_ready_i  input  1  memory completion, sampled only while mem_req_o=1
mem_rdata_i  input  LINE_W  read line, valid with mem_ready_i

Behaviour:
- Reset (async, rst_n=0): all outputs 0; pend_ic, pend_dc, ic_stale cleared; last_grant=DC; state=IDLE. Mid-transaction reset drops mem_req_o immediately; the outstanding transaction is abandoned.
- Capture on every clk edge, independent of state:
  - ic_req_i=1: pend_ic<=1, ic_addr_q<=ic_addr_i. A later pulse overwrites the address.
  - dc_req_i=1: pend_dc<=1, latch dc_we/addr/wdata. A later pulse overwrites.
- States: IDLE, BUSY_IC, BUSY_DC.
- IDLE:
  - Candidates are pend_* flags plus same-cycle request pulses; the incoming pulse's fields take precedence.
  - One candidate: grant it.
  - Both: grant the one not equal to last_grant. The first tie after reset goes to IC.
  - On grant, at the same edge: state<=BUSY_x; mem_req_o<=1; mem_addr_o<={addr[ADDR_W-1:4],4'b0}; mem_we_o, mem_wdata_o loaded (IC: we=0, wdata=0); pend_x<=0; last_grant<=x.
  - Latency: a pulse in cycle T with the arbiter IDLE and no competitor gives mem_req_o=1 in cycle T+1.
- BUSY_x:
  - mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o are held stable.
  - On mem_ready_i=1: mem_req_o<=0, state<=IDLE. This guarantees at least one idle cycle between transactions.
  - BUSY_DC completion: dc_ready_o<=1 for one cycle; dc_rdata_o<=mem_rdata_i when we=0, otherwise unchanged.
  - BUSY_IC completion with ic_stale=0: ic_ready_o<=1 for one cycle; ic_data_o<=mem_rdata_i.
  - BUSY_IC completion with ic_stale=1: no ic_ready_o pulse, ic_data_o unchanged, ic_stale<=0. The newer pend_ic request is served later.
- Stale marking: ic_req_i=1 while state=BUSY_IC sets ic_stale<=1. If the same edge is the completion edge, the completing response is dropped.
- A DCache re-pulse during BUSY_DC does not cancel the in-flight transaction; it is queued as a new pend_dc request.
- mem_ready_i while mem_req_o=0 is ignored.
- ic_ready_o and dc_ready_o are never high in the same cycle; each is high for exactly one cycle per delivered response.
- Data outputs hold their last value between responses.

Test Plan:
- IC pulse addr 0x0000_1234 alone; memory ready 3 cycles after mem_req_o -> mem_addr_o=0x0000_1230, we=0; ic_ready_o pulses once the cycle after mem_ready_i with ic_data_o=mem_rdata_i; mem_req_o drops the same cycle.
- IC and DC pulse in the same cycle after reset -> IC granted first. DC is issued after one idle cycle. The next simultaneous tie goes to DC.
- DC write-back addr 0x8000_0040, wdata=128'hA5..A5 -> mem_we_o=1 with that data; dc_ready_o pulses; dc_rdata_o unchanged.
- IC request 0x100 in flight, IC re-pulse 0x200 before mem_ready_i -> no ic_ready_o for 0x100; second transaction 0x200 issued; a single ic_ready_o with 0x200's line.
- rst_n low while BUSY_DC with mem_req_o=1 -> mem_req_o=0 immediately, all pending flags cleared. After release, no transaction issues until a new pulse.
- mem_ready_i pulsed while IDLE -> no ready outputs, state unchanged.
